// File: rtl/textlcd_rx_if.sv
// HD44780-style 8-bit parallel LCD bus as seen between a text-LCD
// driver (master) and the display-side receiver (slave).
interface textlcd_rx_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (
    output LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );
  modport slave (
    input LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );
endinterface

// File: rtl/textlcd_rx.sv
// Character-LCD bus receiver: oversamples the LCD bus, decodes write
// strobes and mirrors a 2x16 DDRAM plus the display-mode flags.
module textlcd_rx #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        resetn,
  textlcd_rx_if.slave lcd,
  input  logic [4:0]  rd_idx,
  output logic [7:0]  rd_char,
  output logic [6:0]  ac,
  output logic        disp_on,
  output logic        cursor_on,
  output logic        blink_on,
  output logic        two_line,
  output logic        font_5x10,
  output logic        bus_8bit,
  output logic        inc_mode,
  output logic        busy,
  output logic        err,
  output logic        wr_stb
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  // packed bus sample: {E, RS, RW, DATA}
  logic [10:0] r_s1, r_s2, r_s3;
  logic        r_stb, r_rs;
  logic [7:0]  r_dat;
  state_t      r_state, w_state_nx;
  logic [4:0]  r_clr;
  logic [6:0]  r_ac;
  logic        r_disp, r_cur, r_blink;
  logic        r_two, r_font, r_bus8;
  logic        r_inc, r_cg, r_err, r_wr_stb;
  logic [7:0]  r_mem [32];
  logic [7:0]  r_rd;

  logic        w_fall, w_acc, w_ac_ok;
  logic        w_mem_we;
  logic [4:0]  w_mem_wa;
  logic [7:0]  w_mem_wd;
  logic [6:0]  w_ac_step, w_ac_mv;

  // 2-line address map: 0x27 <-> 0x40 and 0x67 <-> 0x00 are adjacent
  function automatic logic [6:0] f_step(
    input logic [6:0] a,
    input logic       up
  );
    logic [6:0] n;
    if (up) begin
      if (a == 7'h27)      n = 7'h40;
      else if (a == 7'h67) n = 7'h00;
      else                 n = a + 7'd1;
    end else begin
      if (a == 7'h40)      n = 7'h27;
      else if (a == 7'h00) n = 7'h67;
      else                 n = a - 7'd1;
    end
    return n;
  endfunction

  assign w_fall = r_s3[10] & ~r_s2[10] & ~r_s3[8];
  assign w_acc  = r_stb & (r_state == S_IDLE);
  assign w_ac_ok = (r_ac[5:4] == 2'b00);
  assign w_ac_step = f_step(r_ac, r_inc);
  assign w_ac_mv   = f_step(r_ac, r_dat[2]);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_s3  <= '0;
      r_stb <= 1'b0;
      r_rs  <= 1'b0;
      r_dat <= '0;
    end else begin
      r_s1  <= {lcd.LCD_E, lcd.LCD_RS,
                lcd.LCD_RW, lcd.LCD_DATA};
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_stb <= w_fall;
      r_rs  <= r_s3[9];
      r_dat <= r_s3[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_CLEAR;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_CLEAR: begin
        if (r_clr == 5'd31) w_state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (r_stb && !r_rs && r_dat == 8'h01)
          w_state_nx = S_CLEAR;
      end
    endcase
  end

  always_comb begin
    w_mem_we = 1'b0;
    w_mem_wa = {r_ac[6], r_ac[3:0]};
    w_mem_wd = r_dat;
    if (r_state == S_CLEAR) begin
      w_mem_we = resetn;
      w_mem_wa = r_clr;
      w_mem_wd = FILL_CHAR;
    end else if (w_acc && r_rs && !r_cg && w_ac_ok) begin
      w_mem_we = resetn;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_clr    <= '0;
      r_ac     <= '0;
      r_disp   <= 1'b0;
      r_cur    <= 1'b0;
      r_blink  <= 1'b0;
      r_two    <= 1'b0;
      r_font   <= 1'b0;
      r_bus8   <= 1'b1;
      r_inc    <= 1'b1;
      r_cg     <= 1'b0;
      r_err    <= 1'b0;
      r_wr_stb <= 1'b0;
    end else begin
      r_wr_stb <= w_acc;
      if (r_state == S_CLEAR) begin
        r_clr <= r_clr + 5'd1;
        if (r_stb) r_err <= 1'b1;
      end
      if (w_acc && r_rs) begin
        if (!r_cg) r_ac <= w_ac_step;
      end else if (w_acc) begin
        unique casez (r_dat)
          8'b1???????: begin
            r_ac <= r_dat[6:0];
            r_cg <= 1'b0;
          end
          8'b01??????: r_cg <= 1'b1;
          8'b001?????: begin
            r_bus8 <= r_dat[4];
            r_two  <= r_dat[3];
            r_font <= r_dat[2];
          end
          8'b0001????: begin
            if (!r_dat[3]) r_ac <= w_ac_mv;
          end
          8'b00001???: begin
            r_disp  <= r_dat[2];
            r_cur   <= r_dat[1];
            r_blink <= r_dat[0];
          end
          8'b000001??: r_inc <= r_dat[1];
          8'b0000001?: r_ac <= '0;
          8'b00000001: begin
            r_ac  <= '0;
            r_inc <= 1'b1;
            r_clr <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_wa] <= w_mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_rd <= '0;
    else         r_rd <= r_mem[rd_idx];
  end

  assign rd_char   = r_rd;
  assign ac        = r_ac;
  assign disp_on   = r_disp;
  assign cursor_on = r_cur;
  assign blink_on  = r_blink;
  assign two_line  = r_two;
  assign font_5x10 = r_font;
  assign bus_8bit  = r_bus8;
  assign inc_mode  = r_inc;
  assign busy      = (r_state == S_CLEAR);
  assign err       = r_err;
  assign wr_stb    = r_wr_stb;

endmodule

// File: tb/tb_textlcd_rx.sv
// Bench for textlcd_rx: directed bring-up sequence plus random bus
// traffic, all checked against a cycle-level behavioural LCD model.
module tb_textlcd_rx;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] rd_idx = '0;
  logic [7:0] rd_char;
  logic [6:0] ac;
  logic       disp_on, cursor_on, blink_on;
  logic       two_line, font_5x10, bus_8bit;
  logic       inc_mode, busy, err, wr_stb;

  textlcd_rx_if lcd_bus();

  textlcd_rx dut (
    .clk       (clk),
    .resetn    (resetn),
    .lcd       (lcd_bus),
    .rd_idx    (rd_idx),
    .rd_char   (rd_char),
    .ac        (ac),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .two_line  (two_line),
    .font_5x10 (font_5x10),
    .bus_8bit  (bus_8bit),
    .inc_mode  (inc_mode),
    .busy      (busy),
    .err       (err),
    .wr_stb    (wr_stb)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int stb_cnt = 0;
  bit rnd_rd = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_cell [32];
  bit         m_known [32];
  int  m_ac, m_clr;
  bit  m_disp, m_cur, m_blink, m_two, m_font, m_bus8;
  bit  m_inc, m_cg, m_err, m_stb, m_act;
  logic [7:0] m_rd;
  bit  m_rdk;
  bit  p_e, p_rs, p_rw;
  logic [7:0] p_d;
  bit  pv [3];
  bit  prs [3];
  logic [7:0] pd [3];

  initial for (int i = 0; i < 32; i++) m_known[i] = 0;

  function automatic int nstep(input int a, input bit up);
    if (up) return (a == 39) ? 64 : (a == 103) ? 0 : (a + 1) % 128;
    return (a == 64) ? 39 : (a == 0) ? 103 : (a + 127) % 128;
  endfunction

  task automatic m_apply(input bit rs, input logic [7:0] d);
    int v;
    v = int'(d);
    if (rs) begin
      if (!m_cg) begin
        if (m_ac < 16) begin
          m_cell[m_ac] = d; m_known[m_ac] = 1;
        end else if (m_ac >= 64 && m_ac < 80) begin
          m_cell[m_ac - 48] = d; m_known[m_ac - 48] = 1;
        end
        m_ac = nstep(m_ac, m_inc);
      end
    end else if (v >= 128) begin
      m_ac = v - 128; m_cg = 0;
    end else if (v >= 64) begin
      m_cg = 1;
    end else if (v >= 32) begin
      m_bus8 = d[4]; m_two = d[3]; m_font = d[2];
    end else if (v >= 16) begin
      if (!d[3]) m_ac = nstep(m_ac, d[2]);
    end else if (v >= 8) begin
      m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
    end else if (v >= 4) begin
      m_inc = d[1];
    end else if (v >= 2) begin
      m_ac = 0;
    end else if (v == 1) begin
      m_ac = 0; m_inc = 1; m_clr = 32;
    end
  endtask

  always @(posedge clk) begin
    bit ev, evrs, fall;
    logic [7:0] evd;
    if (!resetn) begin
      m_act = 1;
      m_ac = 0; m_disp = 0; m_cur = 0; m_blink = 0;
      m_two = 0; m_font = 0; m_bus8 = 1; m_inc = 1;
      m_cg = 0; m_err = 0; m_stb = 0; m_clr = 32;
      m_rd = 0; m_rdk = 1;
      p_e = 0; p_rs = 0; p_rw = 0; p_d = 0;
      for (int i = 0; i < 3; i++) pv[i] = 0;
    end else begin
      m_rd = m_cell[rd_idx];
      m_rdk = m_known[rd_idx];
      m_stb = 0;
      ev = pv[0]; evrs = prs[0]; evd = pd[0];
      pv[0] = pv[1]; prs[0] = prs[1]; pd[0] = pd[1];
      pv[1] = pv[2]; prs[1] = prs[2]; pd[1] = pd[2];
      fall = p_e && !lcd_bus.LCD_E && !p_rw;
      pv[2] = fall; prs[2] = p_rs; pd[2] = p_d;
      p_e = lcd_bus.LCD_E; p_rs = lcd_bus.LCD_RS;
      p_rw = lcd_bus.LCD_RW; p_d = lcd_bus.LCD_DATA;
      if (m_clr > 0) begin
        if (ev) m_err = 1;
        m_cell[32 - m_clr] = 8'h20;
        m_known[32 - m_clr] = 1;
        m_clr--;
      end else if (ev) begin
        m_stb = 1;
        m_apply(evrs, evd);
      end
    end
  end

  always @(negedge clk) begin
    if (wr_stb) stb_cnt++;
    if (m_act) begin
      chk("ac", 32'(ac), 32'(m_ac));
      chk("flags",
          {disp_on, cursor_on, blink_on, two_line,
           font_5x10, bus_8bit, inc_mode, busy},
          {m_disp, m_cur, m_blink, m_two,
           m_font, m_bus8, m_inc, (m_clr > 0)});
      chk("err_stb", {err, wr_stb}, {m_err, m_stb});
      if (m_rdk) chk("rd_char", 32'(rd_char), 32'(m_rd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    if (rnd_rd) rd_idx = 5'($urandom);
  endtask

  task automatic lcd_wr(input bit rs, input bit rw,
                        input logic [7:0] d,
                        input int hi, input int lo);
    tick();
    lcd_bus.LCD_RS = rs; lcd_bus.LCD_RW = rw;
    lcd_bus.LCD_DATA = d; lcd_bus.LCD_E = 1'b1;
    repeat (hi) tick();
    lcd_bus.LCD_E = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic cmd(input logic [7:0] d);
    lcd_wr(1'b0, 1'b0, d, 3, 6);
  endtask

  task automatic dat(input logic [7:0] d);
    lcd_wr(1'b1, 1'b0, d, 3, 6);
  endtask

  task automatic do_reset();
    tick(); resetn = 1'b0;
    tick(); resetn = 1'b1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic read_cell(input int idx, output logic [7:0] v);
    tick(); rd_idx = 5'(idx);
    tick(); v = rd_char;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, s0, allok;
    logic [7:0] v;
    lcd_bus.LCD_E = 0; lcd_bus.LCD_RS = 0;
    lcd_bus.LCD_RW = 0; lcd_bus.LCD_DATA = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    count_busy(n);
    chk("busy_len_reset", 32'(n), 32'd32);
    chk("ac_after_clear", 32'(ac), 32'h0);
    chk("err_after_clear", 32'(err), 32'h0);
    allok = 1;
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      if (v !== 8'h20) allok = 0;
    end
    chk("all_fill", 32'(allok), 32'd1);

    s0 = stb_cnt;
    cmd(8'h3C); cmd(8'h0C); cmd(8'h06);
    chk("mode_flags",
        {two_line, font_5x10, bus_8bit, disp_on,
         cursor_on, blink_on, inc_mode}, 7'b1111001);
    chk("stb_cnt3", 32'(stb_cnt - s0), 32'd3);

    cmd(8'h80); dat(8'h52); dat(8'h4F);
    read_cell(0, v); chk("cell0", 32'(v), 32'h52);
    read_cell(1, v); chk("cell1", 32'(v), 32'h4F);
    chk("ac_02", 32'(ac), 32'h02);
    cmd(8'hC0); dat(8'h50);
    read_cell(16, v); chk("cell16", 32'(v), 32'h50);
    chk("ac_41", 32'(ac), 32'h41);

    cmd(8'hA7); dat(8'h41);
    chk("ac_wrap_40", 32'(ac), 32'h40);
    read_cell(16, v); chk("cell16_kept", 32'(v), 32'h50);
    dat(8'h42);
    read_cell(16, v); chk("cell16_wr", 32'(v), 32'h42);
    cmd(8'h04); cmd(8'h80); dat(8'h20);
    chk("ac_wrap_67", 32'(ac), 32'h67);
    cmd(8'h06);

    cmd(8'h02);
    chk("home_ac", 32'(ac), 32'h0);
    read_cell(1, v); chk("home_keep", 32'(v), 32'h4F);

    s0 = stb_cnt;
    lcd_wr(1'b1, 1'b1, 8'h41, 3, 6);
    chk("rw_no_stb", 32'(stb_cnt - s0), 32'd0);
    chk("rw_ac", 32'(ac), 32'h0);
    read_cell(0, v); chk("rw_cell0", 32'(v), 32'h20);

    cmd(8'h01);
    repeat (4) tick();
    lcd_wr(1'b1, 1'b0, 8'h58, 3, 6);
    chk("err_sticky", 32'(err), 32'd1);
    wait_idle();
    chk("clr_ac", 32'(ac), 32'h0);
    allok = 1;
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      if (v !== 8'h20) allok = 0;
    end
    chk("clr_fill", 32'(allok), 32'd1);

    do_reset();
    repeat (10) tick();
    do_reset();
    count_busy(n);
    chk("busy_len_midreset", 32'(n), 32'd32);
    chk("err_reset", 32'(err), 32'd0);

    rnd_rd = 1;
    for (int t = 0; t < 400; t++) begin
      int k, hi, lo;
      logic [7:0] d;
      k = $urandom_range(0, 9);
      hi = $urandom_range(2, 4);
      lo = $urandom_range(2, 5);
      d = 8'($urandom);
      case (k)
        0, 1, 2, 3, 4: lcd_wr(1'b1, 1'b0, d, hi, lo);
        5: lcd_wr(1'b0, 1'b0, 8'h80 | d, hi, lo);
        6: lcd_wr(1'b0, 1'b0, 8'h10 | (d & 8'h0F), hi, lo);
        7: lcd_wr(1'b0, 1'b0, (d == 8'h01) ? 8'h00 : d, hi, lo);
        8: lcd_wr(d[0], 1'b1, d, hi, lo);
        default: begin
          if ($urandom_range(0, 7) == 0)
            lcd_wr(1'b0, 1'b0, 8'h01, hi, lo);
          else
            lcd_wr(1'b0, 1'b0, d[0] ? 8'h06 : 8'h04, hi, lo);
        end
      endcase
      if (t == 200) do_reset();
    end
    repeat (10) tick();
    rnd_rd = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/textlcd_rx.md
# textlcd_rx

Character-LCD bus receiver: the display-side end of the HD44780-style 8-bit parallel interface our text-LCD drivers produce. It oversamples LCD_E/LCD_RS/LCD_RW/LCD_DATA on the system clock, decodes each write strobe as a command or a data byte, and keeps a 2x16 DDRAM mirror plus display-mode flags. Fabric logic (VGA overlay, testbenches, self-checking demos) can then read back exactly what the LCD would show.

## Interface
- FILL_CHAR, 8'h20, byte written to every cell on reset and on Clear Display
- clk  in  1  system clock; must run at least 4x the LCD_E toggle rate
- resetn  in  1  synchronous, active-low reset
- LCD_E  in  1  enable strobe from driver (asynchronous to clk)
- LCD_RS  in  1  0 = command, 1 = data
- LCD_RW  in  1  0 = write, 1 = read
- LCD_DATA  in  8  bus byte
- rd_idx  in  5  host read index: [4] = line, [3:0] = column
- rd_char  out  8  DDRAM cell at rd_idx, registered
- ac  out  7  address counter
- disp_on, cursor_on, blink_on  out  1 each  display-control flags
- two_line, font_5x10, bus_8bit  out  1 each  function-set flags (N, F, DL)
- inc_mode  out  1  entry-mode I/D
- busy  out  1  clear sequence in progress
- err  out  1  sticky: strobe arrived while busy; cleared only by reset
- wr_stb  out  1  one-cycle pulse per accepted write strobe

## Operation
- Input pipeline: LCD_E, RS, RW, DATA each pass through 2 sync flops (s1, s2) plus a history flop (s3).
- Strobe: s3.E=1 and s2.E=0 (falling edge). The captured RS/RW/DATA are the s3 values, i.e. the last sample taken with E high.
- RW=1 strobes are ignored, with no state change and no wr_stb.
- FSM states: CLEAR, IDLE.
  - CLEAR: write FILL_CHAR to cell clr_idx; clr_idx increments 0..31, then go to IDLE. busy=1 throughout.
  - IDLE: process strobes.
  - Any strobe seen in CLEAR is dropped and sets err.
- Command decode (RS=0), highest set bit wins:
  - 1aaaaaaa: ac = a; cg_sel = 0.
  - 01xxxxxx: cg_sel = 1. Later data writes do not touch DDRAM and do not move ac until the next set-DDRAM command.
  - 001DNFxx: bus_8bit=D, two_line=N, font_5x10=F.
  - 0001SRxx: S=0 moves ac by one (+1 if R=1, -1 if R=0) with the wrap rules below. S=1 is ignored.
  - 00001DCB: disp_on=D, cursor_on=C, blink_on=B.
  - 000001Ix: inc_mode=I. The shift bit is ignored.
  - 0000001x: ac = 0. DDRAM is kept.
  - 00000001: ac = 0, inc_mode = 1, clr_idx = 0, enter CLEAR.
  - 00000000: no-op. It still pulses wr_stb.
- Data write (RS=1, cg_sel=0):
  - If ac is in 0x00–0x0F or 0x40–0x4F, store the byte in cell {ac[6], ac[3:0]}.
  - Otherwise the byte is discarded.
  - In both cases ac steps by ±1 per inc_mode.
- ac wrap rules (2-line address map), applied for both data writes and cursor moves:
  - Increment: 0x27 → 0x40, 0x67 → 0x00.
  - Decrement: 0x40 → 0x27, 0x00 → 0x67.
  - Set-DDRAM values outside 0x00–0x27 and 0x40–0x67 load unchanged. The next step from such a value uses plain 7-bit ±1.
- Read port: rd_char is updated every clk from rd_idx. When a write and a read hit the same cell in the same edge, rd_char returns the old value.

## Timing
- Reset (resetn=0 at an edge):
  - sync flops load E=0, RS=0, RW=0, DATA=0.
  - ac=0, disp_on=0, cursor_on=0, blink_on=0.
  - two_line=0, font_5x10=0, bus_8bit=1, inc_mode=1.
  - cg_sel=0, err=0, wr_stb=0, rd_char=0, clr_idx=0.
  - state=CLEAR, busy=1.
- CLEAR lasts exactly 32 cycles, then busy drops. This holds after reset and after a 0x01 command.
- A strobe arriving on the same edge that CLEAR ends (clr_idx=31) is still dropped and sets err.
- Latency: if LCD_E is first sampled low at edge k, the strobe is detected at edge k+2. Its effects (cells, ac, flags) and wr_stb=1 are visible after edge k+3.
- wr_stb is high for exactly 1 cycle.
- LCD_E high and low phases must each span at least 2 clk periods. RS/RW/DATA must be stable for 2 clk periods before E falls.
- Reset mid-CLEAR or mid-strobe aborts the operation. Reset state is restored on the next edge, and any strobe already in the pipeline is discarded.

## Test plan
- Reset, then resetn=1: busy=1 for 32 cycles; afterwards rd_char=0x20 for all 32 rd_idx, ac=0, err=0.
- Strobes 0x3C, 0x0C, 0x06: two_line=1, font_5x10=1, bus_8bit=1, disp_on=1, cursor_on=0, blink_on=0, inc_mode=1; 3 wr_stb pulses.
- Command 0x80, then data 0x52, 0x4F: cell 0=0x52, cell 1=0x4F, ac=0x02. Command 0xC0, then data 0x50: cell 16=0x50, ac=0x41.
- Wrap: command 0xA7, then data 0x41: no cell changes, ac=0x40. Data 0x42: cell 16=0x42. With inc_mode=0, command 0x80 then data 0x20: ac=0x67.
- Command 0x01, then a data strobe 10 cycles later: strobe dropped, err=1. After 32 cycles all cells=0x20, ac=0.
- RW=1 strobe with DATA 0x41: no wr_stb, no change. Command 0x02 after writes: ac=0, cells retained. Reset asserted during CLEAR: busy restarts a full 32-cycle clear.
